irq_req_capture: RTL and testbench

- Capture stage directly upstream of the 4-input priority encoder.
- Turns raw request lines into sticky pending bits and presents the masked pending vector as the encoder's `din`.
- Clears a pending bit when the downstream consumer acknowledges the index the encoder produced.
- Flags sources that fire again while still pending.

---
 rtl/irq_req_capture.sv | 87 ++++++++
 tb/tb_irq_req_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_req_capture.sv
// Request capture ahead of the priority encoder: sticky pending bits, ack clear, overflow flags.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on every req_in bit before edge detection.

module irq_req_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic ack,
   input  logic ovf_clr,
   output logic p,
   output logic ovf
);

   logic s;
   logic s_q;
   logic ev;

`ifdef IRQ_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], req};
   end

   assign s = sync[1];
`else
   assign s = req;
`endif

   assign ev = s & ~s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= 1'b0;
         p   <= 1'b0;
         ovf <= 1'b0;
      end else begin
         s_q <= s;
         // a fresh event beats a same-cycle ack of this bit
         if (ev)       p <= 1'b1;
         else if (ack) p <= 1'b0;
         if (ovf_clr)             ovf <= 1'b0;
         else if (ev & p & ~ack)  ovf <= 1'b1;
      end
   end

endmodule

module irq_req_capture #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_in,
   input  logic [N-1:0]  mask,
   input  logic          ack_valid,
   input  logic [IW-1:0] ack_id,
   input  logic          ovf_clr,
   output logic [N-1:0]  pend,
   output logic          any_pend,
   output logic [N-1:0]  overflow
);

   logic [N-1:0] p_raw;
   logic [N-1:0] ack_hit;

   // ack_id values >= N match no lane and are therefore ignored
   for (genvar g = 0; g < N; g++) begin : g_lane
      assign ack_hit[g] = ack_valid && (ack_id == IW'(g));

      irq_req_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .req     (req_in[g]),
         .ack     (ack_hit[g]),
         .ovf_clr (ovf_clr),
         .p       (p_raw[g]),
         .ovf     (overflow[g])
      );
   end

   assign pend     = p_raw & ~mask;
   assign any_pend = |pend;

endmodule

// File: tb/tb_irq_req_capture.sv
// Bench for irq_req_capture: directed test-plan sequences plus random traffic against a vector model.

module tb_irq_req_capture;

   localparam int N  = 4;
   localparam int IW = 2;
`ifdef IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_in = '0;
   logic [N-1:0]  mask = '0;
   logic          ack_valid = 1'b0;
   logic [IW-1:0] ack_id = '0;
   logic          ovf_clr = 1'b0;
   logic [N-1:0]  pend;
   logic          any_pend;
   logic [N-1:0]  overflow;

   int total = 0;
   int bad = 0;

   irq_req_capture #(.N(N), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask      (mask),
      .ack_valid (ack_valid),
      .ack_id    (ack_id),
      .ovf_clr   (ovf_clr),
      .pend      (pend),
      .any_pend  (any_pend),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // reference: sampled request history, pending and overflow as plain vectors
   logic [N-1:0] m_hist [LAT];
   logic [N-1:0] m_last, m_p, m_ovf, m_s, m_ev, m_hit;

   assign m_s   = (LAT == 1) ? req_in : m_hist[LAT-2];
   assign m_ev  = m_s & ~m_last;
   assign m_hit = (ack_valid && int'(ack_id) < N) ? (N'(1) << ack_id) : '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_last <= '0;
         m_p    <= '0;
         m_ovf  <= '0;
         for (int i = 0; i < LAT; i++) m_hist[i] <= '0;
      end else begin
         m_last <= m_s;
         m_p    <= m_ev | (m_p & ~m_hit);
         m_ovf  <= ovf_clr ? '0 : (m_ovf | (m_ev & m_p & ~m_hit));
         m_hist[0] <= req_in;
         for (int i = 1; i < LAT; i++) m_hist[i] <= m_hist[i-1];
      end
   end

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_pend", pend, m_p & ~mask);
      chk("model_any", N'(any_pend), N'(|(m_p & ~mask)));
      chk("model_ovf", overflow, m_ovf);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one-cycle pulse on req_in, then wait until it is visible on pend
   task automatic pulse(input logic [N-1:0] v);
      req_in = v;
      tick();
      req_in = '0;
      if (LAT > 1) tick(LAT - 1);
   endtask

   task automatic ack(input int id);
      ack_valid = 1'b1;
      ack_id    = IW'(id);
      tick();
      ack_valid = 1'b0;
   endtask

   initial begin
      tick(2);
      chk("rst_pend", pend, 4'b0000);
      chk("rst_ovf", overflow, 4'b0000);
      chk("rst_any", N'(any_pend), 4'b0000);
      rst_n = 1'b1;
      tick(2);

      pulse(4'b0100);
      chk("t1_pend", pend, 4'b0100);
      chk("t1_any", N'(any_pend), 4'b0001);
      tick(2);
      chk("t1_hold", pend, 4'b0100);
      ack(2);
      chk("t1_ack", pend, 4'b0000);

      pulse(4'b1001);
      chk("t2_pend", pend, 4'b1001);
      ack(3);
      chk("t2_ack3", pend, 4'b0001);
      ack(0);
      chk("t2_ack0", pend, 4'b0000);
      chk("t2_any", N'(any_pend), 4'b0000);

      pulse(4'b0010);
      tick();
      pulse(4'b0010);
      chk("t3_ovf", overflow, 4'b0010);
      chk("t3_pend", pend, 4'b0010);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t3_clr", overflow, 4'b0000);
      req_in = 4'b0010;
      for (int j = 0; j < LAT; j++) begin
         if (j == LAT - 1) begin
            ack_valid = 1'b1;
            ack_id    = 2'd1;
         end
         tick();
         req_in = '0;
      end
      ack_valid = 1'b0;
      chk("t3_evack_pend", pend, 4'b0010);
      chk("t3_evack_ovf", overflow, 4'b0000);
      ack(1);
      chk("t3_cleanup", pend, 4'b0000);

      mask = 4'b1000;
      pulse(4'b1000);
      chk("t4_masked", pend, 4'b0000);
      chk("t4_any", N'(any_pend), 4'b0000);
      mask = 4'b0000;
      #1;
      chk("t4_unmask", pend, 4'b1000);
      mask = 4'b1000;
      ack(3);
      mask = 4'b0000;
      #1;
      chk("t4_ackmasked", pend, 4'b0000);

      tick();
      rst_n  = 1'b0;
      req_in = 4'b1111;
      tick(2);
      rst_n = 1'b1;
      tick(LAT);
      chk("t5_all", pend, 4'b1111);
      chk("t5_ovf", overflow, 4'b0000);
      for (int i = 0; i < N; i++) ack(i);
      chk("t5_acked", pend, 4'b0000);
      tick(4);
      chk("t5_level", pend, 4'b0000);
      req_in = '0;
      tick(LAT + 1);

      pulse(4'b0110);
      tick();
      pulse(4'b0010);
      chk("t6_pend", pend, 4'b0110);
      chk("t6_ovf", overflow, 4'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_pend", pend, 4'b0000);
      chk("t6_async_ovf", overflow, 4'b0000);
      chk("t6_async_any", N'(any_pend), 4'b0000);
      tick();
      rst_n = 1'b1;
      tick(2);

      for (int c = 0; c < 3000; c++) begin
         req_in    = N'($urandom);
         mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ack_valid = ($urandom_range(0, 2) == 0);
         ack_id    = IW'($urandom_range(0, N - 1));
         ovf_clr   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #1;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      ack_valid = 1'b0;
      ovf_clr   = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
